// File: rtl/rsa_cmd_responder.sv
// rsa_cmd_responder
//   FPGA-side endpoint of the ARM command/data link. It decodes 32-bit
//   commands (0 READ, 1 COMPUTE, 2 WRITE), takes one DATA_WIDTH operand
//   from the ARM, starts the compute core, keeps the core's result, returns
//   it to the ARM, and signals completion with a done/done_read handshake.
//   This keeps the link protocol separate from the arithmetic core.
//
// Ports
//   clk, reset                 single clock; synchronous active-high reset
//   arm_to_fpga_cmd/_valid     command word and its qualifier
//   arm_to_fpga_done           operation complete, held until done_read
//   arm_to_fpga_done_read      ARM acknowledge of done
//   arm_to_fpga_data/_valid    operand from the ARM
//   arm_to_fpga_data_ready     responder ready to take the operand
//   fpga_to_arm_data/_valid    result register and its valid flag
//   fpga_to_arm_data_ready     ARM ready to take the result
//   core_start                 one-cycle start pulse to the compute core
//   core_operand               operand register contents
//   core_done, core_result     core completion strobe and its result
//   leds                       {err_sticky, state[2:0]}

module rsa_cmd_responder #(
    parameter int unsigned DATA_WIDTH = 1024,
    parameter int unsigned CMD_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [CMD_WIDTH-1:0]  arm_to_fpga_cmd,
    input  logic                  arm_to_fpga_cmd_valid,

    output logic                  arm_to_fpga_done,
    input  logic                  arm_to_fpga_done_read,

    input  logic                  arm_to_fpga_data_valid,
    output logic                  arm_to_fpga_data_ready,
    input  logic [DATA_WIDTH-1:0] arm_to_fpga_data,

    output logic                  fpga_to_arm_data_valid,
    input  logic                  fpga_to_arm_data_ready,
    output logic [DATA_WIDTH-1:0] fpga_to_arm_data,

    output logic                  core_start,
    output logic [DATA_WIDTH-1:0] core_operand,
    input  logic                  core_done,
    input  logic [DATA_WIDTH-1:0] core_result,

    output logic [3:0]            leds
);

    typedef enum logic [2:0] {
        WAIT_CMD      = 3'd0,
        READ_DATA     = 3'd1,
        COMPUTE_START = 3'd2,
        COMPUTE_WAIT  = 3'd3,
        WRITE_DATA    = 3'd4,
        ASSERT_DONE   = 3'd5
    } state_t;

    localparam logic [CMD_WIDTH-1:0] CMD_READ    = CMD_WIDTH'(0);
    localparam logic [CMD_WIDTH-1:0] CMD_COMPUTE = CMD_WIDTH'(1);
    localparam logic [CMD_WIDTH-1:0] CMD_WRITE   = CMD_WIDTH'(2);

    state_t                  state;
    state_t                  state_next;
    logic [DATA_WIDTH-1:0]   operand_q;
    logic [DATA_WIDTH-1:0]   result_q;
    logic                    err_sticky;

    logic                    operand_load;
    logic                    result_load;
    logic                    err_set;
    logic [2:0]              state_code;

    // State register and the data registers. The data registers only move
    // on their load strobes, so the ARM and the core always see stable values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= WAIT_CMD;
            operand_q  <= '0;
            result_q   <= '0;
            err_sticky <= 1'b0;
        end else begin
            state <= state_next;
            if (operand_load) begin
                operand_q <= arm_to_fpga_data;
            end
            if (result_load) begin
                result_q <= core_result;
            end
            if (err_set) begin
                err_sticky <= 1'b1;
            end
        end
    end

    // Next-state and load-strobe decode. Inputs that arrive in a state that
    // does not consume them (cmd_valid, data_valid, core_done) fall through
    // to the hold-state default and are simply dropped.
    always_comb begin
        state_next   = state;
        operand_load = 1'b0;
        result_load  = 1'b0;
        err_set      = 1'b0;

        case (state)
            WAIT_CMD: begin
                if (arm_to_fpga_cmd_valid) begin
                    if (arm_to_fpga_cmd == CMD_READ) begin
                        state_next = READ_DATA;
                    end else if (arm_to_fpga_cmd == CMD_COMPUTE) begin
                        state_next = COMPUTE_START;
                    end else if (arm_to_fpga_cmd == CMD_WRITE) begin
                        state_next = WRITE_DATA;
                    end else begin
                        // Unknown command: complete it immediately, flag it.
                        state_next = ASSERT_DONE;
                        err_set    = 1'b1;
                    end
                end
            end

            READ_DATA: begin
                // ready is 1 throughout this state, so valid alone is the transfer.
                if (arm_to_fpga_data_valid) begin
                    operand_load = 1'b1;
                    state_next   = ASSERT_DONE;
                end
            end

            COMPUTE_START: begin
                state_next = COMPUTE_WAIT;
            end

            COMPUTE_WAIT: begin
                if (core_done) begin
                    result_load = 1'b1;
                    state_next  = ASSERT_DONE;
                end
            end

            WRITE_DATA: begin
                if (fpga_to_arm_data_ready) begin
                    state_next = ASSERT_DONE;
                end
            end

            ASSERT_DONE: begin
                if (arm_to_fpga_done_read) begin
                    state_next = WAIT_CMD;
                end
            end

            default: begin
                state_next = WAIT_CMD;
            end
        endcase
    end

    // Handshake outputs are pure state decodes: no input reaches them
    // combinationally.
    always_comb begin
        arm_to_fpga_data_ready = (state == READ_DATA);
        core_start             = (state == COMPUTE_START);
        fpga_to_arm_data_valid = (state == WRITE_DATA);
        arm_to_fpga_done       = (state == ASSERT_DONE);
    end

    assign core_operand     = operand_q;
    assign fpga_to_arm_data = result_q;
    assign state_code       = state;
    assign leds             = {err_sticky, state_code};

endmodule
